ahb_slave_fe: RTL

AHB-Lite slave front-end of the bridge: accepts transfers driven by the AHB master BFM, pairs each address phase with its data phase, and pushes requests into an internal request FIFO for the bridge core. Write transfers complete with zero wait states while the FIFO has space. Read transfers stall the bus until the core returns data. Illegal transfers get a two-cycle ERROR response.

---
 rtl/ahb_slave_fe.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ahb_slave_fe.sv
// ahb_slave_fe: AHB-Lite slave front-end pairing address/data phases and queueing requests for the bridge core.
// Optional AHB_SLV_ERR_CHECK_EN flags oversize or misaligned transfers as illegal (ERROR response, no push).
module ahb_slave_fe #(
    parameter int AHB_DATA_WIDTH    = 64,
    parameter int AHB_ADDRESS_WIDTH = 32,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [AHB_ADDRESS_WIDTH-1:0] HADDR,
    input  logic [1:0]                   HTRANS,
    input  logic                         HWRITE,
    input  logic [2:0]                   HSIZE,
    input  logic [2:0]                   HBURST,
    input  logic [AHB_DATA_WIDTH-1:0]    HWDATA,
    output logic                         HREADY,
    output logic                         HRESP,
    output logic [AHB_DATA_WIDTH-1:0]    HRDATA,
    output logic                         req_valid,
    input  logic                         req_ready,
    output logic [AHB_ADDRESS_WIDTH-1:0] req_addr,
    output logic                         req_write,
    output logic [2:0]                   req_size,
    output logic [2:0]                   req_burst,
    output logic                         req_first,
    output logic [AHB_DATA_WIDTH-1:0]    req_wdata,
    input  logic                         rd_valid,
    input  logic [AHB_DATA_WIDTH-1:0]    rd_data,
    input  logic                         rd_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = AHB_ADDRESS_WIDTH + 8 + AHB_DATA_WIDTH;

    typedef enum logic [2:0] {DIDLE, WDATA, RWAIT, RRESP, ERR1, ERR2} state_t;

    state_t                         r_state, w_next, w_cap_st, w_after;
    logic [AHB_ADDRESS_WIDTH-1:0]   r_addr;
    logic                           r_write, r_first, r_pushed;
    logic [2:0]                     r_size, r_burst;
    logic [AHB_DATA_WIDTH-1:0]      r_rdata;
    logic [PW:0]                    r_count;
    logic [PW-1:0]                  r_wp, r_rp;
    logic [EW-1:0]                  r_mem [FIFO_DEPTH];
    logic                           w_cap, w_illegal, w_full, w_empty, w_pop;
    logic                           w_push_w, w_push_r, w_push, w_rd_ok;
    logic [EW-1:0]                  w_entry;

`ifdef AHB_SLV_ERR_CHECK_EN
    localparam logic [2:0] MAX_SZ = (AHB_DATA_WIDTH == 64) ? 3'd3 : 3'd2;
    logic [2:0] w_mask;
    assign w_mask    = (HSIZE >= 3'd3) ? 3'b111 : ((3'b001 << HSIZE) - 3'b001);
    assign w_illegal = (HSIZE > MAX_SZ) || |(HADDR[2:0] & w_mask);
`else
    assign w_illegal = 1'b0;
`endif

    assign w_cap    = HREADY && HTRANS[1];
    assign w_full   = r_count == (PW+1)'(FIFO_DEPTH);
    assign w_empty  = r_count == '0;
    assign w_pop    = !w_empty && req_ready;
    assign w_push_w = r_state == WDATA && !w_full;
    assign w_push_r = r_state == RWAIT && !r_pushed && !w_full;
    assign w_push   = w_push_w || w_push_r;
    assign w_rd_ok  = r_state == RWAIT && r_pushed && rd_valid;
    assign w_entry  = {r_addr, r_write, r_size, r_burst, r_first, w_push_w ? HWDATA : '0};
    assign w_cap_st = w_illegal ? ERR1 : (HWRITE ? WDATA : RWAIT);
    assign w_after  = w_cap ? w_cap_st : DIDLE;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= DIDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = DIDLE;
        case (r_state)
            DIDLE, RRESP, ERR2: w_next = w_after;
            WDATA:              w_next = w_full ? WDATA : w_after;
            RWAIT:              w_next = w_rd_ok ? (rd_err ? ERR1 : RRESP) : RWAIT;
            ERR1:               w_next = ERR2;
            default:            w_next = DIDLE;
        endcase
    end

    always_comb begin
        HREADY = !(r_state == RWAIT || r_state == ERR1 || (r_state == WDATA && w_full));
        HRESP  = r_state == ERR1 || r_state == ERR2;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_size   <= '0;
            r_burst  <= '0;
            r_first  <= 1'b0;
            r_pushed <= 1'b0;
            r_rdata  <= '0;
            r_count  <= '0;
            r_wp     <= '0;
            r_rp     <= '0;
        end else begin
            if (w_cap) begin
                r_addr  <= HADDR;
                r_write <= HWRITE;
                r_size  <= HSIZE;
                r_burst <= HBURST;
                r_first <= HTRANS == 2'b10;
            end
            r_pushed <= w_cap ? 1'b0 : (r_pushed || w_push_r);
            if (w_rd_ok) r_rdata <= rd_data;
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge HCLK) begin
        if (w_push) r_mem[r_wp] <= w_entry;
    end

    assign req_valid = !w_empty;
    assign HRDATA    = r_rdata;
    assign {req_addr, req_write, req_size, req_burst, req_first, req_wdata} = w_empty ? '0 : r_mem[r_rp];
endmodule
